uart_tx: RTL and testbench

- UART transmitter: the transmit end of the team's UART link.
- Frame format: 8N1 (one start bit, 8 data bits LSB first, one stop bit, no parity).
- Bit timing is identical to the uart_rx bit timing, so uart_tx output connected to uart_rx input loops back with the same FREQUENCY and BAUD_RATE.
- A small FIFO with a valid/ready push interface decouples the system logic from the serial line. Queued bytes go out back-to-back with no idle gap.

---
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: 8N1 UART transmitter fed from a small valid/ready FIFO; queued frames go out back-to-back.
module uart_tx #(
    parameter int FREQUENCY    = 20000000,
    parameter int BAUD_RATE    = 9600,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = FREQUENCY / (16 * BAUD_RATE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_byte,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    shift;
    logic [7:0]    clk_cnt;
    logic [2:0]    bit_idx;
    logic          push;
    logic          pop;
    logic          bit_end;

    // Ready comes only from the registered count, so a same-cycle pop never lets a push through at full.
    assign tx_ready = fifo_count < DEPTH;
    assign push     = tx_valid && tx_ready;
    assign bit_end  = clk_cnt == LAST;
    assign pop      = (fifo_count != '0) && (state == IDLE || (state == STOP && bit_end));

    // FIFO storage needs no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= tx_byte;
    end

    // FIFO pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Frame sequencer; line and status outputs are registered and set on the edge that enters each bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift     <= fifo_mem[rd_ptr];
                        clk_cnt   <= '0;
                        state     <= START;
                        tx_serial <= 1'b0;
                        tx_active <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        bit_idx   <= '0;
                        state     <= DATA;
                        tx_serial <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state     <= STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            tx_serial <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx_done <= 1'b1;
                        if (pop) begin
                            shift     <= fifo_mem[rd_ptr];
                            state     <= START;
                            tx_serial <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            tx_active <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx: directed and random checks of uart_tx against a frame-position reference model.
module tb_uart_tx;
    localparam int FREQUENCY  = 1600;
    localparam int BAUD_RATE  = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = 10;
    localparam int FRAME      = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;
    logic [2:0] fifo_count;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mq[$];
    bit         busy = 0;
    int         pos = 0;
    logic [7:0] cur = 8'h00;
    bit         accepted = 0;
    int         ndone = 0;
    logic       smp [700];
    logic [7:0] lb [3];
    logic [7:0] a5;
    logic [7:0] r;
    int         idx;
    int         acc6;

    uart_tx #(
        .FREQUENCY (FREQUENCY),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_byte   (tx_byte),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int p);
        int k;
        k = p / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic model_reset();
        mq.delete();
        busy = 0;
        pos = 0;
        accepted = 0;
    endtask

    task automatic step();
        bit         push;
        bit         pop;
        bit         dn;
        logic [7:0] d;
        push = tx_valid && (mq.size() < FIFO_DEPTH);
        d = tx_byte;
        pop = (mq.size() != 0) && (!busy || pos == FRAME - 1);
        dn = busy && pos == FRAME - 1;
        @(posedge clk);
        if (busy && pos != FRAME - 1) pos++;
        else if (pop) begin
            cur = mq.pop_front();
            busy = 1;
            pos = 0;
        end else busy = 0;
        if (push) mq.push_back(d);
        accepted = push;
        #1;
        if (tx_done === 1'b1) ndone++;
        chk("serial", tx_serial, busy ? line_bit(cur, pos) : 1'b1);
        chk("active", tx_active, busy);
        chk("done", tx_done, dn);
        chk("count", fifo_count, mq.size());
        chk("ready", tx_ready, mq.size() < FIFO_DEPTH);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial", tx_serial, 1);
        chk("rst_active", tx_active, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", tx_ready, 1);
        reset = 1'b0;
        model_reset();

        repeat (1000) step();
        chk("idle_nodone", ndone, 0);

        a5 = 8'hA5;
        tx_valid = 1'b1;
        tx_byte = a5;
        step();
        tx_valid = 1'b0;
        tx_byte = 8'($urandom);
        chk("a5_count0", fifo_count, 1);
        for (int c = 1; c <= 105; c++) begin
            step();
            chk("a5_done", tx_done, c == 101);
            chk("a5_active", tx_active, c <= 100);
            if (c <= 100) chk("a5_line", tx_serial, c <= 10 ? 1'b0 : c >= 91 ? 1'b1 : a5[(c - 11) / 10]);
        end

        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h3C;
        ndone = 0;
        for (int e = 0; e < 320; e++) begin
            tx_valid = e < 3;
            tx_byte = e < 3 ? lb[e] : 8'($urandom);
            step();
            smp[e] = tx_serial;
        end
        tx_valid = 1'b0;
        chk("lb_dones", ndone, 3);
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 8; b++) r[b] = smp[1 + f * FRAME + (b + 1) * CPB + 5];
            chk("lb_start", smp[1 + f * FRAME + 5], 0);
            chk("lb_byte", r, lb[f]);
            chk("lb_stop", smp[1 + f * FRAME + 95], 1);
        end

        idx = 0;
        acc6 = -1;
        for (int e = 0; e < 650; e++) begin
            tx_valid = idx < 6;
            tx_byte = 8'(idx + 1);
            step();
            smp[e] = tx_serial;
            if (accepted) begin
                if (idx == 5) acc6 = e;
                idx++;
            end
            if (e == 4) begin
                chk("bb_full_count", fifo_count, 4);
                chk("bb_full_ready", tx_ready, 0);
            end
            if (e == 100) chk("bb_prepop_ready", tx_ready, 0);
            if (e == 101) begin
                chk("bb_pop_count", fifo_count, 3);
                chk("bb_nobypass", idx, 5);
            end
            if (e >= 1 && e <= 600) chk("bb_active", tx_active, 1);
        end
        tx_valid = 1'b0;
        chk("bb_acc6", acc6, 102);
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < 8; b++) r[b] = smp[1 + f * FRAME + (b + 1) * CPB + 5];
            chk("bb_byte", r, f + 1);
            chk("bb_stop", smp[1 + f * FRAME + 95], 1);
        end

        for (int e = 0; e < 3000; e++) begin
            if (!tx_valid || accepted) begin
                tx_valid = 1'($urandom_range(0, 1));
                tx_byte = 8'($urandom);
            end
            step();
        end
        tx_valid = 1'b0;
        repeat (600) step();
        chk("rnd_drained", fifo_count, 0);

        tx_valid = 1'b1;
        tx_byte = 8'h55;
        step();
        tx_byte = 8'($urandom);
        step();
        tx_byte = 8'($urandom);
        step();
        tx_valid = 1'b0;
        repeat (43) step();
        chk("mid_line_low", tx_serial, 0);
        chk("mid_count", fifo_count, 2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_serial", tx_serial, 1);
        chk("mid_rst_active", tx_active, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_done", tx_done, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        ndone = 0;
        repeat (300) step();
        chk("post_rst_nodone", ndone, 0);
        chk("post_rst_serial", tx_serial, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
